apb_req_bridge: RTL



---
 rtl/apb_req_bridge.sv | 118 +++++++++++
 1 files changed

// File: rtl/apb_req_bridge.sv
// Single-outstanding request-to-APB master bridge: req/gnt/rvalid core port in,
// APB SETUP/ACCESS sequence out, with an optional ACCESS-phase timeout.
module apb_req_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      timeout_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WAIT_LAST  = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
  localparam logic [15:0] WAIT_MAX   = 16'hFFFF;

  state_t      state_q, state_d;
  logic [15:0] wait_q;
  logic        accept, complete, abort;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A ready slave in the last allowed cycle completes normally.
        if (pready_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = accept;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      wait_q    <= 16'd0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_o    <= (state_d != IDLE);
      penable_o <= (state_d == ACCESS);
      rvalid_o  <= complete | abort;

      if (accept) begin
        pwrite_o <= we_i;
        paddr_o  <= addr_i;
        pwdata_o <= wdata_i;
      end

      // Counts low-pready ACCESS cycles; saturates instead of wrapping.
      if (state_q == SETUP) begin
        wait_q <= 16'd0;
      end else if ((state_q == ACCESS) && !pready_i && (wait_q != WAIT_MAX)) begin
        wait_q <= wait_q + 16'd1;
      end

      if (complete) begin
        rdata_o   <= pwrite_o ? '0 : prdata_i;
        err_o     <= pslverr_i;
        timeout_o <= 1'b0;
      end else if (abort) begin
        rdata_o   <= '0;
        err_o     <= 1'b1;
        timeout_o <= 1'b1;
      end
    end
  end

endmodule
